mem_wb_stage: RTL and testbench

MEM/WB pipeline register and writeback stage of the RV32I pipeline. Captures the MEM-stage result and performs load byte/halfword extraction with sign/zero extension. Selects the writeback source and drives the write port of the register file (rd_wren/rd_addr/rd_data). Also flags load faults and maintains the 64-bit retired-instruction counter.

---
 rtl/mem_wb_stage_if.sv | 34 +++
 rtl/mem_wb_stage.sv | 119 +++++++++++
 tb/tb_mem_wb_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bundle: MEM-stage entry fields in, register-file write port,
// status and retired-instruction count out.
interface mem_wb_stage_if #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
);
  logic                 mem_valid_i;
  logic                 mem_rd_wren_i;
  logic [4:0]           mem_rd_addr_i;
  logic [1:0]           mem_wb_sel_i;
  logic [XLEN-1:0]      mem_alu_data_i;
  logic [XLEN-1:0]      mem_pc4_i;
  logic [XLEN-1:0]      mem_ld_word_i;
  logic [2:0]           mem_funct3_i;
  logic [1:0]           mem_addr_lsb_i;
  logic                 rd_wren_o;
  logic [4:0]           rd_addr_o;
  logic [XLEN-1:0]      rd_data_o;
  logic                 wb_valid_o;
  logic                 ld_fault_o;
  logic [INSTRET_W-1:0] instret_o;

  modport master (
    output mem_valid_i, mem_rd_wren_i, mem_rd_addr_i, mem_wb_sel_i,
           mem_alu_data_i, mem_pc4_i, mem_ld_word_i, mem_funct3_i, mem_addr_lsb_i,
    input  rd_wren_o, rd_addr_o, rd_data_o, wb_valid_o, ld_fault_o, instret_o
  );

  modport slave (
    input  mem_valid_i, mem_rd_wren_i, mem_rd_addr_i, mem_wb_sel_i,
           mem_alu_data_i, mem_pc4_i, mem_ld_word_i, mem_funct3_i, mem_addr_lsb_i,
    output rd_wren_o, rd_addr_o, rd_data_o, wb_valid_o, ld_fault_o, instret_o
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register of the RV32I pipeline: load extraction, writeback
// source select, register-file write port, load-fault flag and instret counter.
module mem_wb_stage #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           stall_i,
  input  logic           flush_i,
  mem_wb_stage_if.slave  bus
);

  logic [7:0]           ld_byte_s;
  logic [15:0]          ld_half_s;
  logic [XLEN-1:0]      ld_data_s;
  logic                 ld_fault_s;
  logic [XLEN-1:0]      sel_data_s;
  logic                 fault_s;
  logic                 wren_s;

  logic                 rd_wren_r;
  logic [4:0]           rd_addr_r;
  logic [XLEN-1:0]      rd_data_r;
  logic                 wb_valid_r;
  logic                 ld_fault_r;
  logic [INSTRET_W-1:0] instret_r;

  // Lane extraction and alignment check for the load data path
  always_comb begin
    ld_byte_s  = 8'h00;
    ld_half_s  = 16'h0000;
    ld_data_s  = '0;
    ld_fault_s = 1'b0;
    case (bus.mem_addr_lsb_i)
      2'b00:   ld_byte_s = bus.mem_ld_word_i[7:0];
      2'b01:   ld_byte_s = bus.mem_ld_word_i[15:8];
      2'b10:   ld_byte_s = bus.mem_ld_word_i[23:16];
      2'b11:   ld_byte_s = bus.mem_ld_word_i[31:24];
      default: ld_byte_s = 8'h00;
    endcase
    if (bus.mem_addr_lsb_i[1]) begin
      ld_half_s = bus.mem_ld_word_i[31:16];
    end else begin
      ld_half_s = bus.mem_ld_word_i[15:0];
    end
    case (bus.mem_funct3_i)
      3'b000: ld_data_s = {{(XLEN-8){ld_byte_s[7]}}, ld_byte_s};
      3'b100: ld_data_s = {{(XLEN-8){1'b0}}, ld_byte_s};
      3'b001, 3'b101: begin
        if (bus.mem_addr_lsb_i[0]) begin
          ld_fault_s = 1'b1;
        end else begin
          ld_data_s = {{(XLEN-16){ld_half_s[15] & ~bus.mem_funct3_i[2]}}, ld_half_s};
        end
      end
      3'b010: begin
        if (bus.mem_addr_lsb_i != 2'b00) begin
          ld_fault_s = 1'b1;
        end else begin
          ld_data_s = bus.mem_ld_word_i;
        end
      end
      default: ld_fault_s = 1'b1;
    endcase
  end

  // Writeback source select; the counter tap reads the value before this retirement
  always_comb begin
    sel_data_s = bus.mem_alu_data_i;
    fault_s    = 1'b0;
    case (bus.mem_wb_sel_i)
      2'b00: sel_data_s = bus.mem_alu_data_i;
      2'b01: begin
        sel_data_s = ld_data_s;
        fault_s    = ld_fault_s;
      end
      2'b10:   sel_data_s = bus.mem_pc4_i;
      2'b11:   sel_data_s = instret_r[XLEN-1:0];
      default: sel_data_s = bus.mem_alu_data_i;
    endcase
    wren_s = bus.mem_rd_wren_i & (bus.mem_rd_addr_i != 5'd0) & ~fault_s;
  end

  // Stage register: flush beats stall, and an invalid entry becomes a bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_wren_r  <= 1'b0;
      rd_addr_r  <= 5'd0;
      rd_data_r  <= '0;
      wb_valid_r <= 1'b0;
      ld_fault_r <= 1'b0;
      instret_r  <= '0;
    end else if (flush_i || (!stall_i && !bus.mem_valid_i)) begin
      rd_wren_r  <= 1'b0;
      rd_addr_r  <= 5'd0;
      rd_data_r  <= '0;
      wb_valid_r <= 1'b0;
      ld_fault_r <= 1'b0;
    end else if (!stall_i) begin
      rd_wren_r  <= wren_s;
      rd_addr_r  <= bus.mem_rd_addr_i;
      rd_data_r  <= sel_data_s;
      wb_valid_r <= 1'b1;
      ld_fault_r <= fault_s;
      if (!fault_s) begin
        instret_r <= instret_r + INSTRET_W'(1);
      end
    end
  end

  assign bus.rd_wren_o  = rd_wren_r;
  assign bus.rd_addr_o  = rd_addr_r;
  assign bus.rd_data_o  = rd_data_r;
  assign bus.wb_valid_o = wb_valid_r;
  assign bus.ld_fault_o = ld_fault_r;
  assign bus.instret_o  = instret_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written
// reset/stall/flush/wrap sequences and a randomized run against a reference model.
module tb_mem_wb_stage;

  logic clk_i = 1'b0;
  logic rst_i;
  logic stall_i;
  logic flush_i;
  int   checks   = 0;
  int   failures = 0;

  mem_wb_stage_if #(.XLEN(32), .INSTRET_W(64)) bus ();

  mem_wb_stage #(.XLEN(32), .INSTRET_W(64)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic        wren;
    logic [4:0]  addr;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] word;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic        e_wren;
    logic [31:0] e_data;
    logic        e_fault;
    logic        e_inc;
  } vec_t;

  vec_t vecs[13];

  logic        m_valid, m_wren, m_fault;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [63:0] m_instret;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic w, input logic [4:0] a,
                           input logic [31:0] d, input logic f, input logic [63:0] n);
    check({tag, ".wb_valid"}, 64'(bus.wb_valid_o), 64'(v));
    check({tag, ".rd_wren"},  64'(bus.rd_wren_o),  64'(w));
    check({tag, ".rd_addr"},  64'(bus.rd_addr_o),  64'(a));
    check({tag, ".rd_data"},  64'(bus.rd_data_o),  64'(d));
    check({tag, ".ld_fault"}, 64'(bus.ld_fault_o), 64'(f));
    check({tag, ".instret"},  bus.instret_o,       n);
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [1:0] s,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] word,
                       input logic [2:0] f3, input logic [1:0] lsb);
    bus.mem_valid_i    = v;
    bus.mem_rd_wren_i  = w;
    bus.mem_rd_addr_i  = a;
    bus.mem_wb_sel_i   = s;
    bus.mem_alu_data_i = alu;
    bus.mem_pc4_i      = pc4;
    bus.mem_ld_word_i  = word;
    bus.mem_funct3_i   = f3;
    bus.mem_addr_lsb_i = lsb;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference load: shift the requested lane down, then size by access width
  function automatic void ref_load(input logic [31:0] word, input logic [2:0] f3,
                                   input logic [1:0] lsb, output logic [31:0] data,
                                   output logic fault);
    logic [31:0] sh;
    int          size;
    sh    = word >> (8 * int'(lsb));
    size  = 1 << int'(f3[1:0]);
    fault = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || ((int'(lsb) % size) != 0);
    data  = 32'd0;
    if (!fault) begin
      case (f3)
        3'b000:  data = 32'($signed(sh[7:0]));
        3'b100:  data = 32'(sh[7:0]);
        3'b001:  data = 32'($signed(sh[15:0]));
        3'b101:  data = 32'(sh[15:0]);
        default: data = word;
      endcase
    end
  endfunction

  initial begin
    logic [31:0] ld_d;
    logic        ld_f;
    logic [31:0] sel_d;
    logic        sel_f;
    logic [63:0] exp_n;
    logic [31:0] r_word;
    logic [2:0]  r_f3;
    logic [1:0]  r_lsb;

    // valid wren addr sel alu pc4 word f3 lsb | wren data fault inc
    vecs[0]  = '{1'b1, 1'b1, 5'd5,  2'b00, 32'h0000_1234, 32'h0, 32'h0,         3'b000, 2'd0, 1'b1, 32'h0000_1234, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 5'd2,  2'b01, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, 3'b000, 2'd3, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 5'd3,  2'b01, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, 3'b100, 2'd1, 1'b1, 32'h0000_007F, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 5'd4,  2'b01, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, 3'b001, 2'd2, 1'b1, 32'hFFFF_80FF, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 5'd6,  2'b01, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, 3'b101, 2'd0, 1'b1, 32'h0000_7F01, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 5'd8,  2'b01, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, 3'b010, 2'd0, 1'b1, 32'h80FF_7F01, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 5'd7,  2'b01, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, 3'b010, 2'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 5'd7,  2'b01, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, 3'b110, 2'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 5'd0,  2'b00, 32'h0000_0055, 32'h0, 32'h0,         3'b000, 2'd0, 1'b0, 32'h0000_0055, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 5'd1,  2'b10, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0, 3'b000, 2'd0, 1'b1, 32'h0000_0104, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 5'd9,  2'b00, 32'h0000_0077, 32'h0, 32'h0,         3'b000, 2'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 5'd10, 2'b01, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, 3'b001, 2'd3, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 5'd11, 2'b01, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, 3'b101, 2'd2, 1'b1, 32'h0000_80FF, 1'b0, 1'b1};

    rst_i   = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
    tick();
    tick();
    check_out("reset", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 64'd0);

    // Capture something, stall on it, then reset asynchronously between edges
    rst_i = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h0000_AAAA, 32'h0, 32'h0, 3'b000, 2'd0);
    tick();
    check_out("pre_stall", 1'b1, 1'b1, 5'd9, 32'h0000_AAAA, 1'b0, 64'd1);
    stall_i = 1'b1;
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 64'd0);
    @(negedge clk_i);
    rst_i   = 1'b0;
    stall_i = 1'b0;
    drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 3'b000, 2'd0);
    tick();
    check_out("post_rst", 1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 64'd1);
    drive(1'b1, 1'b1, 5'd6, 2'b00, 32'h0000_0001, 32'h0, 32'h0, 3'b000, 2'd0);
    tick();
    drive(1'b1, 1'b1, 5'd6, 2'b00, 32'h0000_0002, 32'h0, 32'h0, 3'b000, 2'd0);
    tick();
    drive(1'b1, 1'b1, 5'd3, 2'b11, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'b000, 2'd0);
    tick();
    check_out("instret_src", 1'b1, 1'b1, 5'd3, 32'h0000_0003, 1'b0, 64'd4);

    exp_n = 64'd4;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].valid, vecs[i].wren, vecs[i].addr, vecs[i].sel, vecs[i].alu,
            vecs[i].pc4, vecs[i].word, vecs[i].f3, vecs[i].lsb);
      tick();
      exp_n = exp_n + 64'(vecs[i].e_inc);
      check_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].e_wren,
                vecs[i].valid ? vecs[i].addr : 5'd0, vecs[i].e_data, vecs[i].e_fault, exp_n);
    end

    stall_i = 1'b1;
    drive(1'b1, 1'b1, 5'd20, 2'b00, 32'h1111_1111, 32'h0, 32'h0, 3'b000, 2'd0);
    tick();
    check_out("stall1", 1'b1, 1'b1, 5'd11, 32'h0000_80FF, 1'b0, exp_n);
    tick();
    check_out("stall2", 1'b1, 1'b1, 5'd11, 32'h0000_80FF, 1'b0, exp_n);
    flush_i = 1'b1;
    tick();
    check_out("stall_flush", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, exp_n);
    stall_i = 1'b0;
    flush_i = 1'b0;

    force dut.instret_r = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_r;
    #1;
    check("wrap_preset", bus.instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h0000_0042, 32'h0, 32'h0, 3'b000, 2'd0);
    tick();
    check_out("wrap", 1'b1, 1'b1, 5'd5, 32'h0000_0042, 1'b0, 64'd0);

    flush_i = 1'b1;
    tick();
    flush_i   = 1'b0;
    m_valid   = 1'b0;
    m_wren    = 1'b0;
    m_addr    = 5'd0;
    m_data    = 32'h0;
    m_fault   = 1'b0;
    m_instret = 64'd0;
    for (int c = 0; c < 400; c++) begin
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      r_word  = $urandom;
      r_f3    = 3'($urandom_range(0, 7));
      r_lsb   = 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 4) != 0), 1'($urandom), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), $urandom, $urandom, r_word, r_f3, r_lsb);
      ref_load(r_word, r_f3, r_lsb, ld_d, ld_f);
      sel_f = 1'b0;
      case (bus.mem_wb_sel_i)
        2'b00:   sel_d = bus.mem_alu_data_i;
        2'b01:   begin sel_d = ld_d; sel_f = ld_f; end
        2'b10:   sel_d = bus.mem_pc4_i;
        default: sel_d = m_instret[31:0];
      endcase
      if (flush_i || (!stall_i && !bus.mem_valid_i)) begin
        m_valid = 1'b0; m_wren = 1'b0; m_addr = 5'd0; m_data = 32'h0; m_fault = 1'b0;
      end else if (!stall_i) begin
        m_valid = 1'b1;
        m_wren  = bus.mem_rd_wren_i && (bus.mem_rd_addr_i != 5'd0) && !sel_f;
        m_addr  = bus.mem_rd_addr_i;
        m_data  = sel_d;
        m_fault = sel_f;
        if (!sel_f) m_instret = m_instret + 64'd1;
      end
      tick();
      check_out($sformatf("rnd%0d", c), m_valid, m_wren, m_addr, m_data, m_fault, m_instret);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
